// File: rtl/pslip_grant_arb.sv
// pSLIP output-port grant arbiter.
// Round-robin grant per priority with grant/accept iterations.
module pslip_grant_arb #(
  parameter int N        = 16,
  parameter int P        = 16,
  parameter int MAX_ITER = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N-1:0]         req_in,
  input  logic [$clog2(P)-1:0] pri_in,
  output logic                 gnt_valid,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(P)-1:0] gnt_pri,
  input  logic                 acc_valid,
  input  logic                 acc,
  output logic                 busy,
  output logic                 slot_done,
  output logic                 matched,
  output logic [$clog2(N)-1:0] match_idx
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int IT = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IT-1:0]   iter_q, iter_d;
  logic [NW-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]   gpri_q, gpri_d;
  logic            matched_q, matched_d;
  logic [NW-1:0]   midx_q, midx_d;
  logic [NW-1:0]   ptr_q [P];
  logic            ptr_we;
  logic [NW-1:0]   ptr_nxt;

  logic [NW-1:0]   cur_ptr;
  logic            pick_ok;
  logic [NW-1:0]   pick_idx;
  logic [NW:0]     scan;

  assign cur_ptr = ptr_q[pri_in];

  // Scan from the pointer upward, wrapping explicitly at N.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    scan     = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, cur_ptr} + (NW+1)'(k);
      if (scan >= (NW+1)'(N))
        scan = scan - (NW+1)'(N);
      if (!pick_ok && req_in[scan[NW-1:0]]) begin
        pick_ok  = 1'b1;
        pick_idx = scan[NW-1:0];
      end
    end
  end

  assign ptr_nxt = (gnt_q == NW'(N-1)) ? '0
                 : gnt_q + NW'(1);

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    gnt_d     = gnt_q;
    gpri_d    = gpri_q;
    matched_d = matched_q;
    midx_d    = midx_q;
    ptr_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_GRANT;
          matched_d = 1'b0;
          midx_d    = '0;
          iter_d    = '0;
        end
      end
      S_GRANT: begin
        if (pri_in == '0 || req_in == '0 || !pick_ok) begin
          state_d   = S_DONE;
          matched_d = 1'b0;
        end else begin
          gnt_d   = pick_idx;
          gpri_d  = pri_in;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (acc_valid) begin
          if (acc) begin
            matched_d = 1'b1;
            midx_d    = gnt_q;
            ptr_we    = (iter_q == '0);
            state_d   = S_DONE;
          end else if (iter_q == IT'(MAX_ITER-1)) begin
            state_d = S_DONE;
          end else begin
            iter_d  = iter_q + IT'(1);
            state_d = S_GRANT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      iter_q    <= '0;
      gnt_q     <= '0;
      gpri_q    <= '0;
      matched_q <= 1'b0;
      midx_q    <= '0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      gnt_q     <= gnt_d;
      gpri_q    <= gpri_d;
      matched_q <= matched_d;
      midx_q    <= midx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < P; p++)
        ptr_q[p] <= '0;
    end else if (ptr_we) begin
      ptr_q[gpri_q] <= ptr_nxt;
    end
  end

  assign gnt_valid  = (state_q == S_WAIT);
  assign gnt_onehot = gnt_valid ? (N'(1) << gnt_q)
                                : '0;
  assign gnt_pri    = gpri_q;
  assign busy       = (state_q != S_IDLE);
  assign slot_done  = (state_q == S_DONE);
  assign matched    = matched_q;
  assign match_idx  = midx_q;

endmodule

// File: tb/tb_pslip_grant_arb.sv
// Scoreboard bench for pslip_grant_arb.
// Directed slots; monitor checks grants and slot ends.
module tb_pslip_grant_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] req_in;
  logic [3:0]  pri_in;
  logic        gnt_valid;
  logic [15:0] gnt_onehot;
  logic [3:0]  gnt_pri;
  logic        acc_valid;
  logic        acc;
  logic        busy;
  logic        slot_done;
  logic        matched;
  logic [3:0]  match_idx;

  pslip_grant_arb #(.N(16), .P(16), .MAX_ITER(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_in(req_in), .pri_in(pri_in),
    .gnt_valid(gnt_valid), .gnt_onehot(gnt_onehot),
    .gnt_pri(gnt_pri), .acc_valid(acc_valid),
    .acc(acc), .busy(busy), .slot_done(slot_done),
    .matched(matched), .match_idx(match_idx)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [19:0] gq [$];
  logic [4:0]  sq [$];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: new grant on gnt_valid rise, slot end on slot_done.
  logic prev_gv = 1'b0;
  always @(negedge clk) begin
    logic [19:0] ge;
    logic [4:0]  se;
    if (gnt_valid && !prev_gv) begin
      if (gq.size() == 0) begin
        chk(0, "unexp_gnt", {12'h0, gnt_pri, gnt_onehot}, 0);
      end else begin
        ge = gq.pop_front();
        chk({gnt_pri, gnt_onehot} == ge, "gnt",
            {12'h0, gnt_pri, gnt_onehot}, {12'h0, ge});
      end
    end
    if (slot_done) begin
      if (sq.size() == 0) begin
        chk(0, "unexp_done", {27'h0, matched, match_idx}, 0);
      end else begin
        se = sq.pop_front();
        chk({matched, match_idx} == se, "slot",
            {27'h0, matched, match_idx}, {27'h0, se});
      end
    end
    prev_gv <= gnt_valid;
  end

  task automatic run_slot(input logic [15:0] req,
                          input logic [3:0] pri,
                          input int nrej, input bit acc_end,
                          input logic [15:0] exp_oh,
                          input bit exp_m,
                          input logic [3:0] exp_idx,
                          input bit abort, input int stall);
    int ng;
    int w;
    bit last;
    ng = (pri == 0 || req == 0) ? 0 : nrej + (acc_end ? 1 : 0);
    @(posedge clk); #1;
    start = 1'b1; req_in = req; pri_in = pri;
    for (int i = 0; i < ng; i++) gq.push_back({pri, exp_oh});
    if (!abort) sq.push_back({exp_m, exp_idx});
    @(posedge clk); #1;
    start = 1'b0;
    if (ng == 0) begin
      @(posedge clk); #1;
      chk(slot_done == 1'b1, "nogrant_done", slot_done, 1);
      chk(gnt_valid == 1'b0, "nogrant_gv", gnt_valid, 0);
    end
    for (int it = 0; it < ng; it++) begin
      w = 0;
      do begin
        @(posedge clk); #1; w++;
      end while (!gnt_valid && w < 8);
      if (!gnt_valid) begin
        chk(0, "gnt_timeout", w, 1);
        return;
      end
      if (it == 0) chk(w == 1, "gnt_latency", w, 1);
      if (abort) begin
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        chk(gnt_valid == 0 && busy == 0 && slot_done == 0
            && gnt_onehot == 0 && matched == 0,
            "reset_mid", {gnt_valid, busy, slot_done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (it == 0 && stall > 0) begin
        start = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          start = 1'b0;
          chk(gnt_valid && gnt_onehot == exp_oh
              && gnt_pri == pri, "stall_hold",
              gnt_onehot, exp_oh);
        end
      end
      last = (it == ng - 1);
      acc_valid = 1'b1;
      acc = last && acc_end;
      @(posedge clk); #1;
      acc_valid = 1'b0; acc = 1'b0;
      if (last)
        chk(slot_done && !gnt_valid, "done_lat",
            {slot_done, gnt_valid}, 2'b10);
    end
    @(posedge clk); #1;
    chk(!slot_done && !busy && matched == exp_m,
        "post_idle", {slot_done, busy, matched},
        {2'b00, exp_m});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; req_in = '0;
    pri_in = '0; acc_valid = 1'b0; acc = 1'b0;
    #22;
    chk({gnt_valid, gnt_onehot, gnt_pri, busy, slot_done,
         matched, match_idx} == '0, "reset_outs",
        {gnt_valid, busy, slot_done, matched}, 0);
    rst_n = 1'b1;
    // ptr5 -> 3, then abort mid-wait (grant from ptr 3 = input 4)
    run_slot(16'h0014, 4'd5, 0, 1, 16'h0004, 1, 4'd2, 0, 0);
    run_slot(16'h0014, 4'd5, 0, 1, 16'h0010, 0, 4'd0, 1, 0);
    // pointers back at 0
    run_slot(16'h0014, 4'd5, 0, 1, 16'h0004, 1, 4'd2, 0, 0);
    run_slot(16'h0004, 4'd5, 0, 1, 16'h0004, 1, 4'd2, 0, 0);
    run_slot(16'h0014, 4'd5, 0, 1, 16'h0010, 1, 4'd4, 0, 0);
    // ptr5=5: three rejects then accept, pointer stays
    run_slot(16'h0080, 4'd5, 3, 1, 16'h0080, 1, 4'd7, 0, 0);
    run_slot(16'h0180, 4'd5, 0, 1, 16'h0080, 1, 4'd7, 0, 0);
    // ptr5=8: four rejects end the slot unmatched
    run_slot(16'h0100, 4'd5, 4, 0, 16'h0100, 0, 4'd0, 0, 0);
    run_slot(16'h0101, 4'd5, 0, 1, 16'h0100, 1, 4'd8, 0, 0);
    // no request
    run_slot(16'hFFFF, 4'd0, 0, 0, 16'h0000, 0, 4'd0, 0, 0);
    run_slot(16'h0201, 4'd5, 0, 1, 16'h0200, 1, 4'd9, 0, 0);
    // priority isolation, busy start, long stall
    run_slot(16'h0003, 4'd3, 0, 1, 16'h0001, 1, 4'd0, 0, 0);
    run_slot(16'h0401, 4'd5, 0, 1, 16'h0400, 1, 4'd10, 0, 0);
    run_slot(16'h0003, 4'd3, 0, 1, 16'h0002, 1, 4'd1, 0, 20);
    repeat (3) @(posedge clk);
    #1;
    chk(gq.size() == 0 && sq.size() == 0, "queues_empty",
        gq.size() + sq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
